wave_mixer: RTL

//  Parametrised successor to the fixed two-channel wavesum/shift mixer.

---
 rtl/wave_mixer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/wave_mixer.sv
// wave_mixer: mixes NUM_CHANNELS unsigned channel samples with per-channel
// programmable gain and a programmable post-shift, saturating to WAVE_DEPTH bits.
// A single multiplier is time-shared across the channels, one channel per cycle.
//
// Ports:
//   Clock        - system clock, all logic on posedge
//   Reset        - asynchronous active-low reset
//   BusAddress   - register address
//   BusWriteData - register write data
//   BusWrite     - write strobe
//   BusRead      - read strobe
//   BusReadData  - read data, registered, valid one cycle after BusRead
//   SampleTick   - one-cycle pulse starting a new mix
//   Waves        - packed channel samples, channel i at [i*WAVE_DEPTH +: WAVE_DEPTH]
//   Waveform     - mixed output, held between updates
//   SampleValid  - one-cycle pulse while Waveform shows a fresh result
//   Busy         - high while a mix is in progress
//
// Register map (offset from BASE_ADDR):
//   0..NUM_CHANNELS-1 GAIN[i]; NUM_CHANNELS CTRL {SHIFT[3:1], ENABLE[0]};
//   NUM_CHANNELS+1 STATUS {OVERRUN[2] W1C, CLIP[1] W1C, BUSY[0] RO}.
module wave_mixer #(
  parameter int unsigned WAVE_DEPTH   = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned GAIN_WIDTH   = 8,
  parameter logic [15:0] BASE_ADDR    = 16'h0100
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic [15:0]                        BusAddress,
  input  logic [7:0]                         BusWriteData,
  input  logic                               BusWrite,
  input  logic                               BusRead,
  output logic [7:0]                         BusReadData,
  input  logic                               SampleTick,
  input  logic [NUM_CHANNELS*WAVE_DEPTH-1:0] Waves,
  output logic [WAVE_DEPTH-1:0]              Waveform,
  output logic                               SampleValid,
  output logic                               Busy
);

  localparam int unsigned ChW     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned ProdW   = WAVE_DEPTH + GAIN_WIDTH;
  // Sized so the sum of all full-scale products cannot wrap.
  localparam int unsigned AccW    = WAVE_DEPTH + GAIN_WIDTH + $clog2(NUM_CHANNELS) + 1;
  // Only the low byte of a wider gain register is bus-visible.
  localparam int unsigned AccessW = (GAIN_WIDTH < 8) ? GAIN_WIDTH : 8;
  localparam logic [GAIN_WIDTH-1:0] GainReset = GAIN_WIDTH'(1) << (GAIN_WIDTH - 1);
  localparam logic [ChW-1:0]        LastCh    = ChW'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StOutput} state_e;

  state_e                  state_q, state_d;
  logic [ChW-1:0]          ch_q, ch_d;
  logic [AccW-1:0]         acc_q, acc_d;
  logic [WAVE_DEPTH-1:0]   wave_snap_q [NUM_CHANNELS];
  logic [GAIN_WIDTH-1:0]   gain_snap_q [NUM_CHANNELS];
  logic [2:0]              shift_snap_q;
  logic [WAVE_DEPTH-1:0]   wave_q;

  logic [GAIN_WIDTH-1:0]   gain_q [NUM_CHANNELS];
  logic                    enable_q;
  logic [2:0]              shift_q;
  logic                    clip_q, overrun_q;
  logic [7:0]              rdata_q;

  logic                    start, finish;
  logic [ProdW-1:0]        product;
  logic [AccW-1:0]         acc_sum, mix_shifted;
  logic                    mix_clip;
  logic [WAVE_DEPTH-1:0]   mix_sat;

  logic [15:0]             offset;
  logic [NUM_CHANNELS-1:0] gain_sel;
  logic                    ctrl_sel, status_sel;
  logic [7:0]              read_value;

  // Address decode
  always_comb begin
    offset     = BusAddress - BASE_ADDR;
    ctrl_sel   = (offset == 16'(NUM_CHANNELS));
    status_sel = (offset == 16'(NUM_CHANNELS + 1));
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      gain_sel[i] = (offset == 16'(i));
    end
  end

  always_comb begin
    read_value = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (gain_sel[i]) read_value = 8'(gain_q[i][AccessW-1:0]);
    end
    if (ctrl_sel)   read_value = {4'b0, shift_q, enable_q};
    if (status_sel) read_value = {5'b0, overrun_q, clip_q, Busy};
  end

  // Shared multiply-accumulate; acc_sum already includes the current channel so the
  // final result can be registered on the edge that leaves the last ACCUM cycle.
  always_comb begin
    product     = ProdW'(wave_snap_q[ch_q]) * ProdW'(gain_snap_q[ch_q]);
    acc_sum     = acc_q + AccW'(product);
    mix_shifted = acc_sum >> (AccW'(GAIN_WIDTH - 1) + AccW'(shift_snap_q));
    mix_clip    = |(mix_shifted >> WAVE_DEPTH);
    mix_sat     = mix_clip ? '1 : mix_shifted[WAVE_DEPTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    start   = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (SampleTick && enable_q) begin
          start   = 1'b1;
          acc_d   = '0;
          ch_d    = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        acc_d = acc_sum;
        ch_d  = ch_q + 1'b1;
        if (ch_q == LastCh) begin
          finish  = 1'b1;
          state_d = StOutput;
        end
      end
      StOutput: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign Busy        = (state_q != StIdle);
  assign SampleValid = (state_q == StOutput);
  assign Waveform    = wave_q;
  assign BusReadData = rdata_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= StIdle;
      ch_q         <= '0;
      acc_q        <= '0;
      shift_snap_q <= '0;
      wave_q       <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wave_snap_q[i] <= '0;
        gain_snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      if (start) begin
        shift_snap_q <= shift_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          wave_snap_q[i] <= Waves[i*WAVE_DEPTH +: WAVE_DEPTH];
          gain_snap_q[i] <= gain_q[i];
        end
      end
      if (finish) wave_q <= mix_sat;
    end
  end

  // Register block; sticky sets take priority over a same-cycle W1C.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      enable_q  <= 1'b0;
      shift_q   <= '0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) gain_q[i] <= GainReset;
    end else begin
      if (BusRead) rdata_q <= read_value;
      if (BusWrite) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (gain_sel[i]) gain_q[i][AccessW-1:0] <= BusWriteData[AccessW-1:0];
        end
        if (ctrl_sel) begin
          enable_q <= BusWriteData[0];
          shift_q  <= BusWriteData[3:1];
        end
      end
      clip_q    <= (finish && mix_clip) ||
                   (clip_q && !(BusWrite && status_sel && BusWriteData[1]));
      overrun_q <= (SampleTick && Busy) ||
                   (overrun_q && !(BusWrite && status_sel && BusWriteData[2]));
    end
  end

endmodule
